vram_snapshot: RTL and testbench
================================

VRAM_SNAPSHOT -- requirements
Module: vram_snapshot

Interface
REQ-001 The block SHALL have parameter WORDS, default 160, giving the number of LCD RAM nibbles copied per frame (address 0x00-0x9F).
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the address width of the source and video ports.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port vsync, input, 1: one-cycle frame-start pulse from the video timing generator.
REQ-006 Port freeze, input, 1: when high, new snapshots are not started.
REQ-007 Port src_req, output, 1: request for the CPU-side LCD RAM read port.
REQ-008 Port src_gnt, input, 1: grant from the CPU-side arbiter.
REQ-009 Port src_addr, output, ADDR_W: LCD RAM read address.
REQ-010 Port src_data, input, 4: LCD RAM read data, valid one cycle after a granted address.
REQ-011 Port video_addr, input, ADDR_W: scanout read address from the video generator.
REQ-012 Port video_data, output, 4: scanout read data, registered.
REQ-013 Port busy, output, 1: high while a snapshot is in progress.
REQ-014 Port frame_done, output, 1: one-cycle pulse when a snapshot completes and the buffers swap.
REQ-015 Port missed, output, 1: one-cycle pulse when vsync arrives while busy, or while freeze is high.

Function
REQ-016 The block SHALL hold two WORDS x 4 buffers, front and back, selected by a 1-bit front register.
REQ-017 video_data SHALL equal front[video_addr], registered one cycle after video_addr is presented.
REQ-018 video_data SHALL be 0 for video_addr >= WORDS.
REQ-019 The FSM SHALL have states IDLE, REQ, COPY, DRAIN and SWAP.
REQ-020 In IDLE, vsync with freeze low SHALL move the FSM to REQ and clear the issue counter to 0.
REQ-021 In REQ and COPY, src_req SHALL be 1; src_req SHALL be 0 in every other state.
REQ-022 REQ SHALL move to COPY in the first cycle in which src_gnt is high.
REQ-023 An address SHALL count as issued only in a cycle where src_req and src_gnt are both high.
REQ-024 The issue counter SHALL increment by 1 only on an issued cycle; src_addr SHALL equal the issue counter.
REQ-025 The block SHALL write src_data into back[addr] in the cycle after each issued address, and in no other cycle.
REQ-026 src_gnt low during COPY SHALL stall the issue counter with src_addr held; writes for data already in flight SHALL still complete.
REQ-027 After address WORDS-1 is issued, the FSM SHALL go to DRAIN, complete the final write, then go to SWAP.
REQ-028 SWAP SHALL toggle front, pulse frame_done for one cycle and return to IDLE.
REQ-029 vsync arriving in a non-IDLE state, or in IDLE with freeze high, SHALL pulse missed and SHALL NOT restart the copy in progress.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 With continuous grant, a snapshot SHALL take WORDS+3 cycles from vsync to frame_done.

Reset
REQ-032 On reset the block SHALL enter IDLE with front=0 and the issue counter at 0.
REQ-033 On reset src_req, src_addr, video_data, busy, frame_done and missed SHALL all be 0.
REQ-034 Buffer contents SHALL NOT be reset.
REQ-035 Reset during a copy SHALL abort the copy with no swap and no frame_done pulse.

Structure
REQ-036 WORDS, BANK_OFFSET (8'h50) and the FSM state enum SHALL live in the shared tamagotchi video package.
REQ-037 The two buffers SHALL be implemented as one sub-module, snapshot_ram: a 2*WORDS x 4 simple dual-port RAM with {bank, addr} addressing, one write port (copy side) and one registered read port (video side).

Verification
REQ-038 Bench: source RAM holds addr[3:0]; vsync with src_gnt tied 1 -> frame_done 163 cycles later, front=1, and video_addr 0x57 reads 4'h7.
REQ-039 Bench: src_gnt deasserted for 10 cycles after address 20 is issued -> src_addr holds at 21, and the completed buffer matches the source exactly.
REQ-040 Bench: vsync pulses at copy cycle 50 -> missed pulses once, and frame_done arrives on the original schedule.
REQ-041 Bench: freeze=1 with vsync -> missed pulses, src_req stays 0, and front is unchanged.
REQ-042 Bench: reset asserted at copy cycle 80 -> all outputs 0, front=0, and no frame_done.
REQ-043 Bench: video_addr 0xA0 -> video_data 0; the source is modified mid-copy and scanout shows only the old front buffer until the swap.

Source files
------------

// File: rtl/vram_snapshot_pkg.sv
// -----------------------------------------------------------------------------
// vram_snapshot_pkg
// Shared tamagotchi video package: LCD RAM geometry and the snapshot FSM
// state encoding used by the VRAM snapshot block.
//   WORDS       : LCD RAM nibbles copied per frame (0x00-0x9F)
//   BANK_OFFSET : start of the second LCD segment bank in CPU address space
//   state_t     : snapshot FSM states
// -----------------------------------------------------------------------------
package vram_snapshot_pkg;

   localparam int         WORDS       = 160;
   localparam logic [7:0] BANK_OFFSET = 8'h50;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      COPY  = 3'd2,
      DRAIN = 3'd3,
      SWAP  = 3'd4
   } state_t;

endpackage

// File: rtl/vram_snapshot_ram.sv
// -----------------------------------------------------------------------------
// snapshot_ram
// Simple dual-port 2*WORDS x 4 RAM holding the front and back frame buffers.
// Addressing is {bank, addr}; the two banks are packed back to back so the
// array is exactly 2*WORDS deep.
//   clk      : clock
//   wr_en    : write strobe (copy side)
//   wr_bank  : bank selected for the write
//   wr_addr  : nibble address for the write
//   wr_data  : nibble to write
//   rd_bank  : bank selected for the read (video side)
//   rd_addr  : nibble address for the read
//   rd_data  : registered read data, one cycle after rd_bank/rd_addr
// -----------------------------------------------------------------------------
module snapshot_ram #(
   parameter int WORDS  = 160,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [3:0]        rd_data
);

   import vram_snapshot_pkg::*;

   // One extra bit beyond the bank address so bank 1 plus any rd_addr fits.
   localparam int IDX_W = ADDR_W + 1;

   logic [3:0]       mem [0:2*WORDS-1];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   assign wr_idx = wr_bank ? (IDX_W'(WORDS) + IDX_W'(wr_addr)) : IDX_W'(wr_addr);
   assign rd_idx = rd_bank ? (IDX_W'(WORDS) + IDX_W'(rd_addr)) : IDX_W'(rd_addr);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Out-of-range reads are masked by the caller, so no bounds check here.
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/vram_snapshot.sv
// -----------------------------------------------------------------------------
// vram_snapshot
// Copies the CPU-side LCD RAM into a back buffer once per frame and swaps it
// to the front when complete, so scanout never sees a half-updated frame.
//   clk        : clock
//   reset      : asynchronous active-high reset
//   vsync      : one-cycle frame-start pulse
//   freeze     : inhibits starting new snapshots
//   src_req    : request for the LCD RAM read port
//   src_gnt    : grant from the CPU-side arbiter
//   src_addr   : LCD RAM read address (equals the issue counter)
//   src_data   : LCD RAM data, valid one cycle after a granted address
//   video_addr : scanout read address
//   video_data : registered scanout data, 0 for addresses >= WORDS
//   busy       : snapshot in progress
//   frame_done : one-cycle pulse when the buffers swap
//   missed     : one-cycle pulse when a vsync could not start a snapshot
// -----------------------------------------------------------------------------
module vram_snapshot #(
   parameter int WORDS  = vram_snapshot_pkg::WORDS,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              freeze,
   output logic              src_req,
   input  logic              src_gnt,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [3:0]        src_data,
   input  logic [ADDR_W-1:0] video_addr,
   output logic [3:0]        video_data,
   output logic              busy,
   output logic              frame_done,
   output logic              missed
);

   import vram_snapshot_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W + 1)'(WORDS);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt_reg;
   logic              front_reg;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic              frame_done_reg;
   logic              missed_reg;
   logic              in_range_reg;
   logic              issue;
   logic              start;
   logic [3:0]        rd_data;

   assign issue = src_req & src_gnt;
   assign start = (state_reg == IDLE) & vsync & ~freeze;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; the grant that ends REQ also issues address 0.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = REQ;
         REQ:     if (src_gnt) state_next = (cnt_reg == LAST_ADDR) ? DRAIN : COPY;
         COPY:    if (src_gnt && cnt_reg == LAST_ADDR) state_next = DRAIN;
         DRAIN:   state_next = SWAP;
         SWAP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      src_req = 1'b0;
      busy    = 1'b1;
      case (state_reg)
         IDLE:    busy    = 1'b0;
         REQ:     src_req = 1'b1;
         COPY:    src_req = 1'b1;
         default: ;
      endcase
   end

   // Copy datapath. Each issued address is written to the back bank one cycle
   // later, when its data returns; DRAIN covers the final in-flight write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg        <= '0;
         front_reg      <= 1'b0;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= '0;
         frame_done_reg <= 1'b0;
         missed_reg     <= 1'b0;
         in_range_reg   <= 1'b0;
      end else begin
         if (start) begin
            cnt_reg <= '0;
         end else if (issue) begin
            cnt_reg <= cnt_reg + ADDR_W'(1);
         end
         wr_en_reg      <= issue;
         wr_addr_reg    <= cnt_reg;
         if (state_reg == SWAP) begin
            front_reg <= ~front_reg;
         end
         frame_done_reg <= (state_reg == SWAP);
         missed_reg     <= vsync & ((state_reg != IDLE) | freeze);
         in_range_reg   <= ({1'b0, video_addr} < WORDS_EXT);
      end
   end

   snapshot_ram #(
      .WORDS  (WORDS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en_reg),
      .wr_bank (~front_reg),
      .wr_addr (wr_addr_reg),
      .wr_data (src_data),
      .rd_bank (front_reg),
      .rd_addr (video_addr),
      .rd_data (rd_data)
   );

   assign src_addr   = cnt_reg;
   assign video_data = rd_data & {4{in_range_reg}};
   assign frame_done = frame_done_reg;
   assign missed     = missed_reg;

endmodule

// File: tb/tb_vram_snapshot.sv
module tb_vram_snapshot;

   logic       clk;
   logic       reset;
   logic       vsync;
   logic       freeze;
   logic       src_req;
   logic       src_gnt;
   logic [7:0] src_addr;
   logic [3:0] src_data;
   logic [7:0] video_addr;
   logic [3:0] video_data;
   logic       busy;
   logic       frame_done;
   logic       missed;

   logic [3:0] src_mem [0:255];

   int n_checks = 0;
   int n_bad    = 0;

   vram_snapshot #(.WORDS(160), .ADDR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .freeze     (freeze),
      .src_req    (src_req),
      .src_gnt    (src_gnt),
      .src_addr   (src_addr),
      .src_data   (src_data),
      .video_addr (video_addr),
      .video_data (video_data),
      .busy       (busy),
      .frame_done (frame_done),
      .missed     (missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // LCD RAM model: data returns one cycle after the address.
   always @(posedge clk) src_data <= src_mem[src_addr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   task automatic read_video(input logic [7:0] a, output logic [3:0] d);
      video_addr = a;
      @(negedge clk);
      d = video_data;
   endtask

   // Runs one snapshot from a vsync pulse to frame_done (bounded at 1000 cycles).
   task automatic run_frame(input int stall_addr, input int vsync_at, input int mod_at,
                            input int probe_at, output int cycles, output int missed_n,
                            output int vread, output int stall_bad);
      int rem;
      bit stalled;
      cycles = 0; missed_n = 0; vread = -1; stall_bad = 0; rem = 0; stalled = 0;
      @(negedge clk);
      vsync = 1'b1;
      while (cycles < 1000) begin
         @(negedge clk);
         cycles++;
         if (missed) missed_n++;
         if (frame_done) break;
         vsync = (cycles == vsync_at);
         if (cycles == probe_at) video_addr = 8'h10;
         if (cycles == probe_at + 1) vread = int'(video_data);
         if (cycles == mod_at) src_mem[150] = 4'h5;
         if (rem > 0) begin
            if (src_addr != 8'(stall_addr + 1)) stall_bad++;
            rem--;
            if (rem == 0) src_gnt = 1'b1;
         end else if (!stalled && stall_addr >= 0 && src_addr == 8'(stall_addr + 1)) begin
            stalled = 1;
            src_gnt = 1'b0;
            rem     = 10;
         end
      end
      vsync = 1'b0;
   endtask

   initial begin
      int         cyc, mn, vr, sb, mism, req_seen, fd_seen;
      logic [3:0] d;
      logic [3:0] e;

      reset = 1'b1; vsync = 1'b0; freeze = 1'b0; src_gnt = 1'b1; video_addr = 8'h00;
      for (int a = 0; a < 256; a++) src_mem[a] = 4'(a);
      repeat (3) @(negedge clk);
      check_val("rst_src_req", src_req, 0);
      check_val("rst_src_addr", src_addr, 0);
      check_val("rst_video_data", video_data, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_frame_done", frame_done, 0);
      check_val("rst_missed", missed, 0);
      check_val("rst_front", dut.front_reg, 0);
      reset = 1'b0;
      @(negedge clk);

      // Frame 1: pattern addr[3:0], continuous grant.
      run_frame(-1, -1, -1, -1, cyc, mn, vr, sb);
      check_val("f1_latency", cyc, 163);
      check_val("f1_front", dut.front_reg, 1);
      check_val("f1_missed", mn, 0);
      read_video(8'h57, d); check_val("f1_rd_57", d, 4'h7);
      read_video(8'h9F, d); check_val("f1_rd_9F", d, 4'hF);
      read_video(8'h00, d); check_val("f1_rd_00", d, 4'h0);
      read_video(8'hA0, d); check_val("f1_rd_A0", d, 4'h0);
      read_video(8'hFF, d); check_val("f1_rd_FF", d, 4'h0);

      // Frame 2: pattern (3a+1) mod 16, 10-cycle grant stall after address 20.
      for (int a = 0; a < 256; a++) src_mem[a] = 4'(a * 3 + 1);
      run_frame(20, -1, -1, -1, cyc, mn, vr, sb);
      check_val("f2_latency", cyc, 173);
      check_val("f2_stall_hold", sb, 0);
      check_val("f2_front", dut.front_reg, 0);
      mism = 0;
      for (int a = 0; a < 160; a++) begin
         read_video(8'(a), d);
         e = 4'(a * 3 + 1);
         if (d !== e) mism++;
      end
      check_val("f2_buf_match", mism, 0);

      // Frame 3: pattern ~addr[3:0], extra vsync at cycle 50, scanout probe at
      // cycle 60, source[150] rewritten to 5 at cycle 80.
      for (int a = 0; a < 256; a++) src_mem[a] = ~4'(a);
      run_frame(-1, 50, 80, 60, cyc, mn, vr, sb);
      check_val("f3_latency", cyc, 163);
      check_val("f3_missed_once", mn, 1);
      check_val("f3_old_front", vr, 1);
      check_val("f3_front", dut.front_reg, 1);
      read_video(8'h10, d); check_val("f3_rd_10", d, 4'hF);
      read_video(8'd149, d); check_val("f3_rd_149", d, 4'hA);
      read_video(8'd150, d); check_val("f3_rd_150", d, 4'h5);

      // Freeze: vsync must be refused.
      freeze = 1'b1;
      @(negedge clk);
      vsync = 1'b1;
      mn = 0; req_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vsync = 1'b0;
         if (missed) mn++;
         if (src_req) req_seen++;
      end
      check_val("frz_missed", mn, 1);
      check_val("frz_src_req", req_seen, 0);
      check_val("frz_busy", busy, 0);
      check_val("frz_front", dut.front_reg, 1);
      freeze = 1'b0;

      // Reset mid-copy at cycle 80.
      @(negedge clk);
      vsync = 1'b1;
      for (int i = 1; i < 80; i++) begin
         @(negedge clk);
         vsync = 1'b0;
      end
      check_val("rc_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_val("rc_src_req", src_req, 0);
      check_val("rc_src_addr", src_addr, 0);
      check_val("rc_busy", busy, 0);
      check_val("rc_frame_done", frame_done, 0);
      check_val("rc_missed", missed, 0);
      check_val("rc_video_data", video_data, 0);
      check_val("rc_front", dut.front_reg, 0);
      reset = 1'b0;
      fd_seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
      end
      check_val("rc_no_frame_done", fd_seen, 0);
      check_val("rc_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
